mem_stage_lsu: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline, placed after the EX/MEM register. Consumes `ex_mem_flow_t` and produces the registered `mem_wb_flow_t` (it owns the MEM/WB register).
- Drives a req/ack data-memory port with variable latency. Aligns store data into byte lanes and formats load data with sign/zero extension.
- Asserts `stall` to freeze upstream stages while a bus access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 60 ++++++
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu_align.sv | 70 +++++++
 rtl/mem_stage_lsu.sv | 155 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline bundle types for the MEM stage and its neighbours.
// EX/MEM and MEM/WB flow structs, LSU state and funct3 codes.
package pipeline_flow;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] WbSel;
    logic [4:0] rd;
  } wb_ctrl_t;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc_incr;
    logic [XLEN-1:0] pc_offset;
    mem_ctrl_t       mem_ctrl;
    wb_ctrl_t        wb_ctrl;
  } ex_mem_flow_t;

  typedef struct packed {
    wb_ctrl_t        wb_ctrl;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_incr;
    logic [XLEN-1:0] pc_offset;
    logic [XLEN-1:0] mem_data;
    logic            misalign;
  } mem_wb_flow_t;

  typedef enum logic {
    IDLE,
    BUSY
  } lsu_state_e;

  function automatic mem_wb_flow_t pass_flow(
    input ex_mem_flow_t f
  );
    mem_wb_flow_t o;
    o            = '0;
    o.wb_ctrl    = f.wb_ctrl;
    o.alu_result = f.alu_result;
    o.pc_incr    = f.pc_incr;
    o.pc_offset  = f.pc_offset;
    return o;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack port between the LSU (master) and memory (slave).
// Request fields stay stable from req rise until the one-cycle ack.
interface mem_stage_lsu_if;
  import pipeline_flow::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment for stores and load extension (combinational).
// LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of masking.
module lsu_align
  import pipeline_flow::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      a_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o,
  output logic            misal_o
);

  logic        is_h;
  logic        is_w;
  logic [1:0]  a_eff;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign is_h = (funct3_i == F3_H) || (funct3_i == F3_HU);
  assign is_w = (funct3_i == F3_W);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_o = (is_h && a_i[0]) || (is_w && (a_i != 2'b00));
  assign a_eff   = a_i;
`else
  assign misal_o = 1'b0;
  // Drop the offending low bits so the access lands naturally aligned.
  always_comb begin
    a_eff = a_i;
    if (is_h) a_eff = {a_i[1], 1'b0};
    if (is_w) a_eff = 2'b00;
  end
`endif

  always_comb begin
    byte_s = rdata_i[7:0];
    case (a_eff)
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    half_s = a_eff[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rs2_i;
    ldata_o = rdata_i;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << a_eff;
        wdata_o = {4{rs2_i[7:0]}};
        ldata_o = {{24{byte_s[7]}}, byte_s};
      end
      F3_H: begin
        be_o    = 4'b0011 << {a_eff[1], 1'b0};
        wdata_o = {2{rs2_i[15:0]}};
        ldata_o = {{16{half_s[15]}}, half_s};
      end
      F3_BU:   ldata_o = {24'd0, byte_s};
      F3_HU:   ldata_o = {16'd0, half_s};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: drives the req/ack data port and owns the MEM/WB register.
// LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being masked.
module mem_stage_lsu
  import pipeline_flow::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  ex_mem_flow_t inflow,
  output logic         stall,
  output logic         out_valid,
  output mem_wb_flow_t outflow,
  output logic         trap,
  mem_stage_lsu_if.master dmem
);

  lsu_state_e      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      alo_q, alo_d;
  logic            ov_q, ov_d;
  mem_wb_flow_t    of_q, of_d;
  logic            trap_q, trap_d;
  logic            stall_c;

  logic            busy;
  logic            mem_op;
  logic [2:0]      al_f3;
  logic [1:0]      al_a;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_misal;

  assign busy   = (state_q == BUSY);
  assign mem_op = in_valid &&
                  (inflow.mem_ctrl.MemRead || inflow.mem_ctrl.MemWrite);

  // One aligner: store lanes while issuing, load format while waiting.
  assign al_f3 = busy ? f3_q  : inflow.mem_ctrl.funct3;
  assign al_a  = busy ? alo_q : inflow.alu_result[1:0];

  lsu_align u_align (
    .funct3_i (al_f3),
    .a_i      (al_a),
    .rs2_i    (inflow.rs2_data),
    .rdata_i  (dmem.rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ldata_o  (al_ldata),
    .misal_o  (al_misal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_op && !al_misal) state_d = BUSY;
      BUSY: if (dmem.ack)            state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    of_d    = of_q;
    ov_d    = 1'b0;
    trap_d  = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && al_misal) begin
          ov_d                 = 1'b1;
          trap_d               = 1'b1;
          of_d                 = pass_flow(inflow);
          of_d.misalign        = 1'b1;
          of_d.wb_ctrl.RegWrite = 1'b0;
        end else if (mem_op) begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = inflow.mem_ctrl.MemWrite;
          addr_d  = {inflow.alu_result[XLEN-1:2], 2'b00};
          wdata_d = al_wdata;
          be_d    = inflow.mem_ctrl.MemWrite ? al_be : 4'b1111;
          f3_d    = inflow.mem_ctrl.funct3;
          alo_d   = inflow.alu_result[1:0];
          of_d    = pass_flow(inflow);
        end else if (in_valid) begin
          ov_d = 1'b1;
          of_d = pass_flow(inflow);
        end
      end
      BUSY: begin
        stall_c = !dmem.ack;
        if (dmem.ack) begin
          req_d         = 1'b0;
          ov_d          = 1'b1;
          of_d.mem_data = we_q ? '0 : al_ldata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      ov_q    <= 1'b0;
      of_q    <= '0;
      trap_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      ov_q    <= ov_d;
      of_q    <= of_d;
      trap_q  <= trap_d;
    end
  end

  assign stall      = rst_n && stall_c;
  assign out_valid  = ov_q;
  assign outflow    = of_q;
  assign trap       = trap_q;
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; inputs change and outputs are
// sampled on the falling edge.
module tb_mem_stage_lsu;
  import pipeline_flow::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  ex_mem_flow_t inflow;
  logic         stall;
  logic         out_valid;
  mem_wb_flow_t outflow;
  logic         trap;
  int           checks = 0;
  int           failures = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inflow    (inflow),
    .stall     (stall),
    .out_valid (out_valid),
    .outflow   (outflow),
    .trap      (trap),
    .dmem      (bus)
  );

  always #5 clk = ~clk;

  function automatic ex_mem_flow_t mk(
    input logic        rd_, input logic wr_,
    input logic [2:0]  f3,
    input logic [31:0] a, input logic [31:0] rs2
  );
    ex_mem_flow_t f;
    f                  = '0;
    f.alu_result       = a;
    f.rs2_data         = rs2;
    f.pc_incr          = 32'h0000_2004;
    f.pc_offset        = 32'h0000_3000;
    f.mem_ctrl.MemRead = rd_;
    f.mem_ctrl.MemWrite = wr_;
    f.mem_ctrl.funct3  = f3;
    f.wb_ctrl.RegWrite = rd_;
    f.wb_ctrl.WbSel    = 2'b01;
    f.wb_ctrl.rd       = 5'd7;
    return f;
  endfunction

  // Drives one mem op from a falling edge; ack arrives on req cycle lat.
  task automatic mem_op(
    input  ex_mem_flow_t f, input int lat, input logic [31:0] rd,
    output int req_cyc, output logic stable, output logic stall_ok,
    output logic [3:0] be, output logic [31:0] wd,
    output logic [31:0] ad, output logic we,
    output logic ov, output mem_wb_flow_t of, output logic req_after
  );
    in_valid = 1'b1;
    inflow   = f;
    #1;
    stall_ok = (stall === 1'b1);
    req_cyc  = 0;
    stable   = 1'b1;
    be = '0; wd = '0; ad = '0; we = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) begin
        be = bus.be; wd = bus.wdata; ad = bus.addr; we = bus.we;
      end
      if (bus.req === 1'b1) req_cyc++;
      if (bus.be !== be || bus.wdata !== wd ||
          bus.addr !== ad || bus.we !== we) stable = 1'b0;
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (i == lat - 1) begin
        bus.ack   = 1'b1;
        bus.rdata = rd;
        #1;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end
    end
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.rdata = '0;
    ov        = out_valid;
    of        = outflow;
    req_after = bus.req;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inflow   = mk(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", stall);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || trap !== 1'b0 || bus.req !== 1'b0 ||
        bus.we !== 1'b0 || bus.be !== 4'h0 || bus.addr !== 32'h0 ||
        bus.wdata !== 32'h0 || outflow !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b trap=%b req=%b be=%h of=%h exp=0",
               out_valid, trap, bus.req, bus.be, outflow);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    in_valid = 1'b1;
    inflow   = mk(1'b0, 1'b0, F3_W, 32'h1234, 32'h0);
    inflow.wb_ctrl.RegWrite = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL alu_stall got=%b exp=0", stall);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || outflow.alu_result !== 32'h1234 ||
        outflow.mem_data !== 32'h0 || bus.req !== 1'b0) begin
      failures++;
      $display("FAIL alu_result got ov=%b alu=%h md=%h req=%b exp 1/1234/0/0",
               out_valid, outflow.alu_result, outflow.mem_data, bus.req);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL alu_bubble got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_sw();
    int n; logic st, sok, w, ov, ra;
    logic [3:0] be; logic [31:0] wd, ad; mem_wb_flow_t of;
    mem_op(mk(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF), 3, 32'h0,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    in_valid = 1'b0;
    checks++;
    if (n != 3 || st !== 1'b1 || w !== 1'b1) begin
      failures++;
      $display("FAIL sw_req got req_cyc=%0d stable=%b we=%b exp 3/1/1",
               n, st, w);
    end
    checks++;
    if (be !== 4'hF || wd !== 32'hDEADBEEF || ad !== 32'h100) begin
      failures++;
      $display("FAIL sw_bus got be=%h wd=%h ad=%h exp f/deadbeef/100",
               be, wd, ad);
    end
    checks++;
    if (sok !== 1'b1) begin
      failures++;
      $display("FAIL sw_stall got=%b exp=1", sok);
    end
    checks++;
    if (ov !== 1'b1 || of.mem_data !== 32'h0 || ra !== 1'b0 ||
        of.alu_result !== 32'h100 || of.pc_incr !== 32'h2004 ||
        of.pc_offset !== 32'h3000) begin
      failures++;
      $display("FAIL sw_done got ov=%b md=%h req=%b alu=%h pci=%h exp 1/0/0/100/2004",
               ov, of.mem_data, ra, of.alu_result, of.pc_incr);
    end
  endtask

  task automatic test_loads();
    int n; logic st, sok, w, ov, ra;
    logic [3:0] be; logic [31:0] wd, ad; mem_wb_flow_t of;
    logic [2:0]  f3v [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_W};
    logic [31:0] av  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] ev  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                             32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      mem_op(mk(1'b1, 1'b0, f3v[i], av[i], 32'h0), 1 + (i % 2),
             32'h80FF7F01, n, st, sok, be, wd, ad, w, ov, of, ra);
      checks++;
      if (ov !== 1'b1 || of.mem_data !== ev[i] ||
          of.wb_ctrl.RegWrite !== 1'b1) begin
        failures++;
        $display("FAIL load%0d got ov=%b md=%h rw=%b exp 1/%h/1",
                 i, ov, of.mem_data, of.wb_ctrl.RegWrite, ev[i]);
      end
      checks++;
      if (be !== 4'hF || w !== 1'b0 || ad !== 32'h100 || sok !== 1'b1) begin
        failures++;
        $display("FAIL load%0d_bus got be=%h we=%b ad=%h stall_ok=%b exp f/0/100/1",
                 i, be, w, ad, sok);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_store_lanes();
    int n; logic st, sok, w, ov, ra;
    logic [3:0] be; logic [31:0] wd, ad; mem_wb_flow_t of;
    mem_op(mk(1'b0, 1'b1, F3_H, 32'h102, 32'h0000ABCD), 1, 32'h0,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    checks++;
    if (ad !== 32'h100 || be !== 4'b1100 || wd !== 32'hABCDABCD) begin
      failures++;
      $display("FAIL sh_lanes got ad=%h be=%b wd=%h exp 100/1100/abcdabcd",
               ad, be, wd);
    end
    mem_op(mk(1'b0, 1'b1, F3_B, 32'h101, 32'h1234565A), 2, 32'h0,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    in_valid = 1'b0;
    checks++;
    if (ad !== 32'h100 || be !== 4'b0010 || wd !== 32'h5A5A5A5A ||
        ov !== 1'b1) begin
      failures++;
      $display("FAIL sb_lanes got ad=%h be=%b wd=%h ov=%b exp 100/0010/5a5a5a5a/1",
               ad, be, wd, ov);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic st, sok, w, ov, ra;
    logic [3:0] be; logic [31:0] wd, ad; mem_wb_flow_t of;
    mem_op(mk(1'b1, 1'b0, F3_BU, 32'h201, 32'h0), 1, 32'h0000C300,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    checks++;
    if (ov !== 1'b1 || of.mem_data !== 32'h000000C3) begin
      failures++;
      $display("FAIL b2b_first got ov=%b md=%h exp 1/000000c3", ov, of.mem_data);
    end
    mem_op(mk(1'b1, 1'b0, F3_H, 32'h302, 32'h0), 1, 32'h9ABC0000,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    in_valid = 1'b0;
    checks++;
    if (ov !== 1'b1 || of.mem_data !== 32'hFFFF9ABC || ad !== 32'h300 ||
        of.alu_result !== 32'h302 || sok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got ov=%b md=%h ad=%h alu=%h exp 1/ffff9abc/300/302",
               ov, of.mem_data, ad, of.alu_result);
    end
  endtask

  task automatic test_reset_busy();
    in_valid = 1'b1;
    inflow   = mk(1'b1, 1'b0, F3_W, 32'h200, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req !== 1'b1) begin
      failures++;
      $display("FAIL rbusy_req got=%b exp=1", bus.req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || out_valid !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rbusy_drop got req=%b ov=%b stall=%b exp 0/0/0",
               bus.req, out_valid, stall);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    bus.ack   = 1'b1;
    bus.rdata = 32'h55AA55AA;
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.rdata = '0;
    checks++;
    if (out_valid !== 1'b0 || bus.req !== 1'b0) begin
      failures++;
      $display("FAIL rbusy_late_ack got ov=%b req=%b exp 0/0",
               out_valid, bus.req);
    end
    in_valid = 1'b1;
    inflow   = mk(1'b0, 1'b0, F3_W, 32'h55, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || outflow.alu_result !== 32'h55) begin
      failures++;
      $display("FAIL rbusy_idle got ov=%b alu=%h exp 1/55",
               out_valid, outflow.alu_result);
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    in_valid = 1'b1;
    inflow   = mk(1'b1, 1'b0, F3_W, 32'h101, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mis_stall got=%b exp=0", stall);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || trap !== 1'b1 || outflow.misalign !== 1'b1 ||
        outflow.wb_ctrl.RegWrite !== 1'b0 || bus.req !== 1'b0) begin
      failures++;
      $display("FAIL mis_trap got ov=%b trap=%b mis=%b rw=%b req=%b exp 1/1/1/0/0",
               out_valid, trap, outflow.misalign,
               outflow.wb_ctrl.RegWrite, bus.req);
    end
    @(negedge clk);
    checks++;
    if (trap !== 1'b0 || bus.req !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_pulse got trap=%b req=%b ov=%b exp 0/0/0",
               trap, bus.req, out_valid);
    end
`else
    int n; logic st, sok, w, ov, ra;
    logic [3:0] be; logic [31:0] wd, ad; mem_wb_flow_t of;
    mem_op(mk(1'b1, 1'b0, F3_W, 32'h101, 32'h0), 2, 32'h80FF7F01,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    checks++;
    if (ad !== 32'h100 || be !== 4'hF || ov !== 1'b1 ||
        of.mem_data !== 32'h80FF7F01 || of.misalign !== 1'b0 ||
        trap !== 1'b0) begin
      failures++;
      $display("FAIL mis_lw got ad=%h be=%h ov=%b md=%h mis=%b trap=%b exp 100/f/1/80ff7f01/0/0",
               ad, be, ov, of.mem_data, of.misalign, trap);
    end
    mem_op(mk(1'b1, 1'b0, F3_H, 32'h103, 32'h0), 1, 32'h80FF7F01,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    checks++;
    if (of.mem_data !== 32'hFFFF80FF || ov !== 1'b1) begin
      failures++;
      $display("FAIL mis_lh got md=%h ov=%b exp ffff80ff/1", of.mem_data, ov);
    end
    mem_op(mk(1'b0, 1'b1, F3_H, 32'h103, 32'h00001122), 1, 32'h0,
           n, st, sok, be, wd, ad, w, ov, of, ra);
    in_valid = 1'b0;
    checks++;
    if (be !== 4'b1100 || wd !== 32'h11221122 || trap !== 1'b0) begin
      failures++;
      $display("FAIL mis_sh got be=%b wd=%h trap=%b exp 1100/11221122/0",
               be, wd, trap);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inflow    = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    @(negedge clk);
    test_sw();
    @(negedge clk);
    test_loads();
    @(negedge clk);
    test_store_lanes();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_reset_busy();
    @(negedge clk);
    test_misalign();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
